// File: rtl/psx_mem_arbiter.sv
// psx_mem_arbiter
//   Shares the single GPU DDR bridge client port between three requesters:
//   0 = display fetch (strict priority, bounded by STARVE_LIMIT),
//   1 = GPU draw engine, 2 = CPU/MDEC transfers (1 and 2 round-robin).
//   Exactly one bridge command is in flight at a time. The owner keeps the
//   bridge until its command completes, and read data is routed back to it.
//
// Ports
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_req[2:0]              per-requester request, held until o_ack
//   i_reqWrite[2:0]         per-requester direction (1 = write)
//   i_reqSize[5:0]          2 bits/requester: 0=8B, 1=32B, 2=4B
//   i_reqAdr[44:0]          15 bits/requester, 32-byte block address
//   i_reqSubAdr[8:0]        3 bits/requester, 4-byte sub-address
//   i_reqMask[47:0]         16 bits/requester, write mask
//   i_reqData[767:0]        256 bits/requester, write data
//   o_ack[2:0]              command issued for that requester (1 cycle)
//   o_rdValid[2:0]          o_rdData valid for that requester (1 cycle)
//   o_rdData[255:0]         bridge read data, shared by all requesters
//   o_command + fields      registered command to the bridge
//   i_busyClient            bridge busy
//   i_dataValidClient       bridge read data valid
//   i_dataClient[255:0]     bridge read data
//   o_owner[1:0]            current owner, 3 = none
//   o_idle                  arbiter is in IDLE
module psx_mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [2:0]   i_req,
  input  logic [2:0]   i_reqWrite,
  input  logic [5:0]   i_reqSize,
  input  logic [44:0]  i_reqAdr,
  input  logic [8:0]   i_reqSubAdr,
  input  logic [47:0]  i_reqMask,
  input  logic [767:0] i_reqData,
  output logic [2:0]   o_ack,
  output logic [2:0]   o_rdValid,
  output logic [255:0] o_rdData,
  output logic         o_command,
  output logic         o_writeElseRead,
  output logic [1:0]   o_commandSize,
  output logic [14:0]  o_targetAddr,
  output logic [2:0]   o_subAddr,
  output logic [15:0]  o_writeMask,
  output logic [255:0] o_dataClient,
  input  logic         i_busyClient,
  input  logic         i_dataValidClient,
  input  logic [255:0] i_dataClient,
  output logic [1:0]   o_owner,
  output logic         o_idle
);

  typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT, WR_WAIT} state_t;

  localparam logic [3:0] LIMIT   = 4'(STARVE_LIMIT);
  localparam logic [1:0] NO_OWNER = 2'd3;

  state_t         state_q, state_d;
  logic [1:0]     owner_q, owner_d;
  logic [3:0]     starve_q, starve_d;
  // 0: requester 1 is next in the round-robin, 1: requester 2 is next
  logic           rr_q, rr_d;
  // Marks the first WR_WAIT cycle, in which bridge busy is not yet meaningful
  logic           wrFirst_q, wrFirst_d;

  logic           wr_q, wr_d;
  logic [1:0]     size_q, size_d;
  logic [14:0]    adr_q, adr_d;
  logic [2:0]     sub_q, sub_d;
  logic [15:0]    mask_q, mask_d;
  logic [255:0]   data_q, data_d;

  logic           force12;
  logic [1:0]     win;

  // Winner selection: requester 0 first unless it has starved 1/2 long enough
  always_comb begin
    force12 = (starve_q == LIMIT) && (i_req[1] || i_req[2]);
    if (i_req[0] && !force12) begin
      win = 2'd0;
    end else if (!rr_q) begin
      win = i_req[1] ? 2'd1 : 2'd2;
    end else begin
      win = i_req[2] ? 2'd2 : 2'd1;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    starve_d  = starve_q;
    rr_d      = rr_q;
    wrFirst_d = 1'b0;
    wr_d      = wr_q;
    size_d    = size_q;
    adr_d     = adr_q;
    sub_d     = sub_q;
    mask_d    = mask_q;
    data_d    = data_q;
    o_command = 1'b0;
    o_ack     = 3'b000;
    o_rdValid = 3'b000;

    case (state_q)
      IDLE: begin
        if (|i_req) begin
          for (int n = 0; n < 3; n++) begin
            if (win == 2'(n)) begin
              wr_d   = i_reqWrite[n];
              size_d = i_reqSize[n*2 +: 2];
              adr_d  = i_reqAdr[n*15 +: 15];
              sub_d  = i_reqSubAdr[n*3 +: 3];
              mask_d = i_reqMask[n*16 +: 16];
              data_d = i_reqData[n*256 +: 256];
            end
          end
          owner_d = win;
          state_d = ISSUE;
          if (win == 2'd0) begin
            if ((i_req[1] || i_req[2]) && (starve_q != LIMIT)) begin
              starve_d = starve_q + 4'd1;
            end
          end else begin
            starve_d = 4'd0;
            rr_d     = (win == 2'd1);
          end
        end
      end
      ISSUE: begin
        if (!i_busyClient) begin
          o_command = 1'b1;
          o_ack     = 3'(3'b001 << owner_q);
          state_d   = wr_q ? WR_WAIT : RD_WAIT;
          wrFirst_d = wr_q;
        end
      end
      RD_WAIT: begin
        if (i_dataValidClient) begin
          o_rdValid = 3'(3'b001 << owner_q);
          state_d   = IDLE;
          owner_d   = NO_OWNER;
        end
      end
      WR_WAIT: begin
        if (!wrFirst_q && !i_busyClient) begin
          state_d = IDLE;
          owner_d = NO_OWNER;
        end
      end
      default: begin
        state_d = IDLE;
        owner_d = NO_OWNER;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      owner_q   <= NO_OWNER;
      starve_q  <= 4'd0;
      rr_q      <= 1'b0;
      wrFirst_q <= 1'b0;
      wr_q      <= 1'b0;
      size_q    <= 2'd0;
      adr_q     <= 15'd0;
      sub_q     <= 3'd0;
      mask_q    <= 16'd0;
      data_q    <= 256'd0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      starve_q  <= starve_d;
      rr_q      <= rr_d;
      wrFirst_q <= wrFirst_d;
      wr_q      <= wr_d;
      size_q    <= size_d;
      adr_q     <= adr_d;
      sub_q     <= sub_d;
      mask_q    <= mask_d;
      data_q    <= data_d;
    end
  end

  assign o_rdData        = i_dataClient;
  assign o_writeElseRead = wr_q;
  assign o_commandSize   = size_q;
  assign o_targetAddr    = adr_q;
  assign o_subAddr       = sub_q;
  assign o_writeMask     = mask_q;
  assign o_dataClient    = data_q;
  assign o_owner         = owner_q;
  assign o_idle          = (state_q == IDLE);

endmodule

// File: tb/tb_psx_mem_arbiter.sv
module tb_psx_mem_arbiter;

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic [2:0]   i_req;
  logic [2:0]   i_reqWrite;
  logic [5:0]   i_reqSize;
  logic [44:0]  i_reqAdr;
  logic [8:0]   i_reqSubAdr;
  logic [47:0]  i_reqMask;
  logic [767:0] i_reqData;
  logic [2:0]   o_ack;
  logic [2:0]   o_rdValid;
  logic [255:0] o_rdData;
  logic         o_command;
  logic         o_writeElseRead;
  logic [1:0]   o_commandSize;
  logic [14:0]  o_targetAddr;
  logic [2:0]   o_subAddr;
  logic [15:0]  o_writeMask;
  logic [255:0] o_dataClient;
  logic         i_busyClient;
  logic         i_dataValidClient;
  logic [255:0] i_dataClient;
  logic [1:0]   o_owner;
  logic         o_idle;

  psx_mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req(i_req), .i_reqWrite(i_reqWrite), .i_reqSize(i_reqSize),
    .i_reqAdr(i_reqAdr), .i_reqSubAdr(i_reqSubAdr), .i_reqMask(i_reqMask),
    .i_reqData(i_reqData),
    .o_ack(o_ack), .o_rdValid(o_rdValid), .o_rdData(o_rdData),
    .o_command(o_command), .o_writeElseRead(o_writeElseRead),
    .o_commandSize(o_commandSize), .o_targetAddr(o_targetAddr),
    .o_subAddr(o_subAddr), .o_writeMask(o_writeMask),
    .o_dataClient(o_dataClient),
    .i_busyClient(i_busyClient), .i_dataValidClient(i_dataValidClient),
    .i_dataClient(i_dataClient),
    .o_owner(o_owner), .o_idle(o_idle)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [2:0]  req;
    logic [2:0]  wr;
    logic        busy;
    logic        dv;
    logic        e_cmd;
    logic [2:0]  e_ack;
    logic [2:0]  e_rv;
    logic [1:0]  e_own;
    logic        e_idle;
    logic [14:0] e_adr;
  } vec_t;

  localparam int NV = 25;
  vec_t tbl [NV];

  int nchk = 0;
  int nerr = 0;
  int grants [16];
  int ng;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int ack_idx(input logic [2:0] a);
    case (a)
      3'b001:  return 0;
      3'b010:  return 1;
      3'b100:  return 2;
      default: return 3;
    endcase
  endfunction

  // Holds the given requests (bridge never busy, no read data) until n acks
  // have been seen or the cycle budget runs out; then drops all requests.
  task automatic collect(input logic [2:0] req, input logic [2:0] wr, input int n);
    int cyc;
    ng = 0;
    cyc = 0;
    while (ng < n && cyc < 300) begin
      @(negedge i_clk);
      i_req = req;
      i_reqWrite = wr;
      i_busyClient = 1'b0;
      i_dataValidClient = 1'b0;
      #1;
      if (o_ack != 3'b000) begin
        grants[ng] = ack_idx(o_ack);
        ng++;
      end
      cyc++;
    end
    chk("grant_count", 256'(ng), 256'(n));
    @(negedge i_clk);
    i_req = 3'b000;
  endtask

  initial begin
    int rr_exp [4];
    int st_exp [10];
    int cyc;
    rr_exp = '{1, 2, 1, 2};
    st_exp = '{0, 0, 0, 0, 2, 0, 0, 0, 0, 2};

    // requester fields: r0 adr 0x010, r1 adr 0x123 size 32B, r2 adr 0x456 4B sub 1 mask 3
    i_reqAdr    = {15'h0456, 15'h0123, 15'h0010};
    i_reqSize   = {2'd2, 2'd1, 2'd0};
    i_reqSubAdr = {3'd1, 3'd0, 3'd0};
    i_reqMask   = {16'h0003, 16'h0000, 16'h0000};
    i_reqData   = {{32{8'h22}}, {32{8'h11}}, {32{8'h00}}};
    i_dataClient = {32{8'hA5}};
    i_req = 3'b000;
    i_reqWrite = 3'b000;
    i_busyClient = 1'b0;
    i_dataValidClient = 1'b0;
    i_rst = 1'b1;

    //                req     wr     bsy  dv   cmd  ack     rv      own   idle adr
    tbl[0]  = '{3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 2'd3, 1'b1, 15'h000};
    tbl[1]  = '{3'b010, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 2'd3, 1'b1, 15'h000};
    tbl[2]  = '{3'b010, 3'b000, 1'b0, 1'b0, 1'b1, 3'b010, 3'b000, 2'd1, 1'b0, 15'h123};
    tbl[3]  = '{3'b000, 3'b000, 1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 2'd1, 1'b0, 15'h123};
    tbl[4]  = '{3'b000, 3'b000, 1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 2'd1, 1'b0, 15'h123};
    tbl[5]  = '{3'b000, 3'b000, 1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 2'd1, 1'b0, 15'h123};
    tbl[6]  = '{3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 3'b000, 3'b010, 2'd1, 1'b0, 15'h123};
    tbl[7]  = '{3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 2'd3, 1'b1, 15'h123};
    tbl[8]  = '{3'b001, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 2'd3, 1'b1, 15'h123};
    tbl[9]  = '{3'b001, 3'b000, 1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 2'd0, 1'b0, 15'h010};
    tbl[10] = '{3'b001, 3'b000, 1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 2'd0, 1'b0, 15'h010};
    tbl[11] = '{3'b001, 3'b000, 1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 2'd0, 1'b0, 15'h010};
    tbl[12] = '{3'b001, 3'b000, 1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 2'd0, 1'b0, 15'h010};
    tbl[13] = '{3'b001, 3'b000, 1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 2'd0, 1'b0, 15'h010};
    tbl[14] = '{3'b001, 3'b000, 1'b0, 1'b0, 1'b1, 3'b001, 3'b000, 2'd0, 1'b0, 15'h010};
    tbl[15] = '{3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 2'd0, 1'b0, 15'h010};
    tbl[16] = '{3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 3'b000, 3'b001, 2'd0, 1'b0, 15'h010};
    tbl[17] = '{3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 2'd3, 1'b1, 15'h010};
    tbl[18] = '{3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 3'b000, 3'b000, 2'd3, 1'b1, 15'h010};
    tbl[19] = '{3'b100, 3'b100, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 2'd3, 1'b1, 15'h010};
    tbl[20] = '{3'b100, 3'b100, 1'b0, 1'b0, 1'b1, 3'b100, 3'b000, 2'd2, 1'b0, 15'h456};
    tbl[21] = '{3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 2'd2, 1'b0, 15'h456};
    tbl[22] = '{3'b000, 3'b000, 1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 2'd2, 1'b0, 15'h456};
    tbl[23] = '{3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 2'd2, 1'b0, 15'h456};
    tbl[24] = '{3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 2'd3, 1'b1, 15'h456};

    // reset state
    repeat (2) @(negedge i_clk);
    #1;
    chk("rst_command", 256'(o_command), 256'(0));
    chk("rst_ack", 256'(o_ack), 256'(0));
    chk("rst_rdValid", 256'(o_rdValid), 256'(0));
    chk("rst_owner", 256'(o_owner), 256'(3));
    chk("rst_idle", 256'(o_idle), 256'(1));
    chk("rst_targetAddr", 256'(o_targetAddr), 256'(0));
    chk("rst_writeMask", 256'(o_writeMask), 256'(0));
    chk("rst_dataClient", o_dataClient, 256'(0));
    @(negedge i_clk);
    i_rst = 1'b0;

    // table-driven cycle vectors
    for (int i = 0; i < NV; i++) begin
      if (i != 0) @(negedge i_clk);
      i_req = tbl[i].req;
      i_reqWrite = tbl[i].wr;
      i_busyClient = tbl[i].busy;
      i_dataValidClient = tbl[i].dv;
      #1;
      chk($sformatf("v%0d_command", i), 256'(o_command), 256'(tbl[i].e_cmd));
      chk($sformatf("v%0d_ack", i), 256'(o_ack), 256'(tbl[i].e_ack));
      chk($sformatf("v%0d_rdValid", i), 256'(o_rdValid), 256'(tbl[i].e_rv));
      chk($sformatf("v%0d_owner", i), 256'(o_owner), 256'(tbl[i].e_own));
      chk($sformatf("v%0d_idle", i), 256'(o_idle), 256'(tbl[i].e_idle));
      chk($sformatf("v%0d_targetAddr", i), 256'(o_targetAddr), 256'(tbl[i].e_adr));
      if (i == 6) chk("v6_rdData", o_rdData, {32{8'hA5}});
      if (i == 2) chk("v2_size", 256'(o_commandSize), 256'(1));
    end

    // fields of the last command (requester 2 write) are held in IDLE
    chk("hold_writeMask", 256'(o_writeMask), 256'(16'h0003));
    chk("hold_subAddr", 256'(o_subAddr), 256'(1));
    chk("hold_size", 256'(o_commandSize), 256'(2));
    chk("hold_write", 256'(o_writeElseRead), 256'(1));
    chk("hold_data", o_dataClient, {32{8'h22}});

    // round-robin between 1 and 2 (writes)
    collect(3'b110, 3'b110, 4);
    for (int g = 0; g < 4; g++) chk($sformatf("rr_grant%0d", g), 256'(grants[g]), 256'(rr_exp[g]));
    repeat (4) @(negedge i_clk);
    #1;
    chk("rr_back_idle", 256'(o_idle), 256'(1));

    // starvation: 0 back-to-back with 2 held
    collect(3'b101, 3'b101, 10);
    for (int g = 0; g < 10; g++) chk($sformatf("starve_grant%0d", g), 256'(grants[g]), 256'(st_exp[g]));
    repeat (4) @(negedge i_clk);
    #1;
    chk("starve_back_idle", 256'(o_idle), 256'(1));

    // reset while waiting for read data
    cyc = 0;
    i_req = 3'b010;
    i_reqWrite = 3'b000;
    #1;
    while (o_ack[1] !== 1'b1 && cyc < 20) begin
      @(negedge i_clk);
      #1;
      cyc++;
    end
    chk("rd_ack_seen", 256'(o_ack), 256'(3'b010));
    @(negedge i_clk);
    i_req = 3'b000;
    #1;
    chk("rdwait_owner", 256'(o_owner), 256'(1));
    chk("rdwait_idle", 256'(o_idle), 256'(0));
    i_rst = 1'b1;
    #1;
    chk("rst_mid_owner", 256'(o_owner), 256'(3));
    chk("rst_mid_idle", 256'(o_idle), 256'(1));
    @(negedge i_clk);
    i_dataValidClient = 1'b1;
    #1;
    chk("rst_mid_rdValid", 256'(o_rdValid), 256'(0));
    @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    chk("after_rst_rdValid", 256'(o_rdValid), 256'(0));
    @(negedge i_clk);
    i_dataValidClient = 1'b0;
    #1;
    chk("after_rst_idle", 256'(o_idle), 256'(1));
    chk("after_rst_command", 256'(o_command), 256'(0));

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/psx_mem_arbiter.md
# psx_mem_arbiter

Three-way arbiter/sequencer in front of the GPU DDR bridge client port (32-byte-block PSX memory protocol). It shares the single bridge between display fetch (requester 0), GPU draw engine (requester 1) and CPU/MDEC transfers (requester 2). Requester 0 has strict priority, bounded by an anti-starvation limit. Requesters 1 and 2 are served round-robin. The block issues exactly one bridge command at a time, holds ownership until that command completes, and routes read data back to the owner.

## Interface
Parameters:
- STARVE_LIMIT, 4: consecutive requester-0 grants, while 1 or 2 are pending, before 1/2 are forced to win; legal range 1..15.

Ports:
- Clock and reset: one clock, `i_clk`; reset is asynchronous and active-high, `i_rst`.
- i_clk  in  1  clock
- i_rst  in  1  asynchronous active-high reset
- i_req  in  3  request per requester, held until its o_ack
- i_reqWrite  in  3  per requester: 0=read, 1=write
- i_reqSize  in  6  2 bits per requester [2n+1:2n]: 0=8B, 1=32B, 2=4B
- i_reqAdr  in  45  15 bits per requester, 32-byte block address
- i_reqSubAdr  in  9  3 bits per requester, 4-byte sub-address
- i_reqMask  in  48  16 bits per requester, 16-bit write mask
- i_reqData  in  768  256 bits per requester, write data
- o_ack  out  3  one-cycle pulse when that requester's command is issued
- o_rdValid  out  3  one-cycle pulse: o_rdData valid for that requester
- o_rdData  out  256  read data, shared by all requesters
- o_command  out  1  bridge command strobe
- o_writeElseRead, o_commandSize[1:0], o_targetAddr[14:0], o_subAddr[2:0], o_writeMask[15:0], o_dataClient[255:0]  out  command fields to the bridge
- i_busyClient  in  1  bridge busy
- i_dataValidClient  in  1  bridge read data valid
- i_dataClient  in  256  bridge read data
- o_owner  out  2  current owner index; 3 = none
- o_idle  out  1  1 when the state is IDLE

## Operation
- States: IDLE, ISSUE, RD_WAIT, WR_WAIT.
- IDLE, with any i_req bit set:
  - Select the winner and register all of its fields into command registers.
  - Set o_owner to the winner and go to ISSUE.
- Winner selection:
  - Requester 0 wins if i_req[0]=1, unless starveCnt==STARVE_LIMIT and (i_req[1] or i_req[2]).
  - Otherwise, among 1 and 2, the one equal to rrNext wins if it is requesting; if not, the other one wins.
- starveCnt (4 bits):
  - Increments, saturating at STARVE_LIMIT, on a requester-0 grant while i_req[1] or i_req[2] is set.
  - Clears on any grant to requester 1 or 2.
  - Holds otherwise.
- rrNext: set to 2 after granting 1, set to 1 after granting 2.
- ISSUE:
  - If i_busyClient=0: o_command=1 and o_ack[owner]=1 for this single cycle, then go to RD_WAIT (read) or WR_WAIT (write).
  - If i_busyClient=1: stay in ISSUE; o_command=0.
- RD_WAIT:
  - On i_dataValidClient=1: o_rdValid[owner]=1 in the same cycle, then go to IDLE.
  - o_rdData = i_dataClient combinationally at all times.
- WR_WAIT:
  - The first cycle in this state ignores i_busyClient.
  - From the second cycle on, i_busyClient=0 sends the state to IDLE.
- i_dataValidClient outside RD_WAIT is ignored; no o_rdValid is produced.
- Requester rules:
  - Hold i_req and all of its fields stable until o_ack.
  - A request still asserted after o_ack is treated as a new request.
  - It is only sampled in IDLE.
- o_command fields are registered. While not in ISSUE they hold their last value, but o_command stays 0.

## Timing
- Reset values:
  - State IDLE; o_command, o_ack, o_rdValid all 0.
  - o_owner=3, o_idle=1.
  - starveCnt=0, rrNext=1.
  - All command field registers 0.
- Issue latency, with the bridge not busy:
  - request seen in IDLE at cycle t → o_command and o_ack at t+1.
- Read completion:
  - i_dataValidClient at cycle k → o_rdValid at k.
  - IDLE at k+1; the next o_command no earlier than k+2.
- Write completion:
  - o_command at t; i_busyClient low at cycle w ≥ t+2 → IDLE at w+1.
- At most one outstanding bridge command; o_command is never asserted outside ISSUE.
- Simultaneous requests are resolved in a single IDLE cycle; losers stay pending, with no ack.
- Reset mid-operation: immediate return to IDLE. The pending read is dropped and no o_rdValid follows; the bridge is reset by the same reset.

## Test plan
- Single read, requester 1: size=1, adr=0x0123, bridge busy 3 cycles, data 0xA5..A5 → o_command one cycle after req with o_targetAddr=0x0123; o_ack[1] in that same cycle; o_rdValid[1] with o_rdData=0xA5..A5; o_rdValid[0] and o_rdValid[2] stay 0.
- Round-robin: requesters 1 and 2 held continuously (writes), requester 0 idle → grant order 1,2,1,2; o_ack never pulses twice in a row for the same index.
- Starvation: requester 0 requests back-to-back, requester 2 held, STARVE_LIMIT=4 → grants 0,0,0,0,2,0,…; starveCnt clears after the grant to 2.
- Backpressure: i_busyClient held 1 during ISSUE for 5 cycles → o_command=0 throughout, then a single one-cycle o_command with unchanged fields once busy drops.
- Write mask passthrough: requester 2 write, size=2, sub=3'b001, mask=0x0003 → o_writeMask=0x0003, o_subAddr=1; the state returns to IDLE only after busy falls, never in the first WR_WAIT cycle.
- Reset in RD_WAIT: assert i_rst, then pulse i_dataValidClient → no o_rdValid; o_owner=3 and o_idle=1 immediately.
